// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: collects one bit-reversed FFT frame per bank and
// streams it back out in natural index order while the other bank fills.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no finished bank pending, output stream idle
// READ  | issuing one read per cycle from rd_bank_q at rd_cnt_q
module fft_bitrev_reorder #(
   parameter int float_len     = 32,
   parameter int bram_addr_len = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*float_len-1:0] data_in,
   input  logic                   data_in_valid,
   output logic [2*float_len-1:0] data_out,
   output logic                   data_out_valid,
   output logic                   data_out_last
);
   localparam int W = 2*float_len;
   localparam int N = 1 << bram_addr_len;
   localparam logic [bram_addr_len-1:0] LAST_IDX = '1;

   typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

   logic [W-1:0]             bank0_q [N];
   logic [W-1:0]             bank1_q [N];
   logic [bram_addr_len-1:0] wr_cnt_q;
   logic                     wr_bank_q;
   logic                     done_q;
   logic                     done_bank_q;
   logic [bram_addr_len-1:0] rd_cnt_q;
   logic                     rd_bank_q;
   state_t                   state_q;
   logic [bram_addr_len-1:0] wr_addr_d;
   logic [W-1:0]             rd_data_d;
   logic                     rd_en_d;

   always_comb begin
      wr_addr_d = '0;
      for (int i = 0; i < bram_addr_len; i++) begin
         wr_addr_d[i] = wr_cnt_q[bram_addr_len-1-i];
      end
   end

   always_comb begin
      rd_en_d   = (state_q == READ);
      rd_data_d = rd_bank_q ? bank1_q[rd_cnt_q] : bank0_q[rd_cnt_q];
   end

   // RAM contents survive reset; only the write enable is gated by it.
   always_ff @(posedge clk) begin
      if (rst && data_in_valid) begin
         if (wr_bank_q) begin
            bank1_q[wr_addr_d] <= data_in;
         end else begin
            bank0_q[wr_addr_d] <= data_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         done_q      <= 1'b0;
         done_bank_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (data_in_valid) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
            if (wr_cnt_q == LAST_IDX) begin
               wr_bank_q   <= ~wr_bank_q;
               done_q      <= 1'b1;
               done_bank_q <= wr_bank_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         rd_cnt_q  <= '0;
         rd_bank_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (done_q) begin
                  state_q   <= READ;
                  rd_bank_q <= done_bank_q;
                  rd_cnt_q  <= '0;
               end
            end
            READ: begin
               rd_cnt_q <= rd_cnt_q + 1'b1;
               // A frame finishing exactly now chains straight on with no bubble.
               if (rd_cnt_q == LAST_IDX) begin
                  if (done_q) begin
                     rd_bank_q <= done_bank_q;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out       <= '0;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else begin
         data_out       <= rd_en_d ? rd_data_d : '0;
         data_out_valid <= rd_en_d;
         data_out_last  <= rd_en_d && (rd_cnt_q == LAST_IDX);
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench: an 8-point instance for directed frame/reset cases and a
// 64-point instance for randomized frames with random valid gaps.
module tb_fft_bitrev_reorder;
   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:0]  rst_n;
   logic [63:0] din [2];
   logic [1:0]  din_v;
   logic [63:0] dout0, dout1;
   logic        dv0, dv1, dl0, dl1;

   exp_t        q_exp   [2][$];
   int          q_start [2][$];
   logic [63:0] fbuf    [2][64];
   int          fcnt [2];
   int          pos  [2];
   int          cyc;
   int          tests;
   int          fails;

   always #5 clk = ~clk;

   fft_bitrev_reorder #(.float_len(32), .bram_addr_len(3)) u8 (
      .clk(clk), .rst(rst_n[0]), .data_in(din[0]), .data_in_valid(din_v[0]),
      .data_out(dout0), .data_out_valid(dv0), .data_out_last(dl0));

   fft_bitrev_reorder #(.float_len(32), .bram_addr_len(6)) u64 (
      .clk(clk), .rst(rst_n[1]), .data_in(din[1]), .data_in_valid(din_v[1]),
      .data_out(dout1), .data_out_valid(dv1), .data_out_last(dl1));

   function automatic int nbits(int d);
      return (d == 0) ? 3 : 6;
   endfunction

   function automatic int bitrev(int j, int b);
      int r = 0;
      for (int i = 0; i < b; i++) begin
         if (((j >> i) & 1) != 0) r += 1 << (b - 1 - i);
      end
      return r;
   endfunction

   task automatic check(string name, int d, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d @cyc %0d: got %h, required %h", name, d, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // One call = one clock cycle of stimulus; the model records accepted samples.
   task automatic drive(int d, logic v, logic [63:0] x);
      int n;
      @(posedge clk);
      #1;
      n        = 1 << nbits(d);
      din[d]   = x;
      din_v[d] = v;
      if (v && rst_n[d]) begin
         fbuf[d][fcnt[d]] = x;
         fcnt[d]++;
         if (fcnt[d] == n) begin
            for (int j = 0; j < n; j++) begin
               exp_t e;
               e.data = fbuf[d][bitrev(j, nbits(d))];
               e.last = (j == n - 1);
               q_exp[d].push_back(e);
            end
            // accepted at edge cyc+1, first output two edges later
            q_start[d].push_back(cyc + 3);
            fcnt[d] = 0;
         end
      end
   endtask

   task automatic idle(int d, int n);
      for (int i = 0; i < n; i++) drive(d, 1'b0, 64'h0);
   endtask

   task automatic do_reset(int d);
      @(posedge clk);
      #1;
      rst_n[d] = 1'b0;
      din[d]   = 64'hDEAD_BEEF_0BAD_F00D;
      din_v[d] = 1'b1;
      fcnt[d]  = 0;
      @(posedge clk);
      #1;
      rst_n[d] = 1'b1;
      din_v[d] = 1'b0;
   endtask

   always @(negedge clk) begin
      logic        v, l;
      logic [63:0] o;
      exp_t        e;
      for (int d = 0; d < 2; d++) begin
         v = (d == 0) ? dv0 : dv1;
         l = (d == 0) ? dl0 : dl1;
         o = (d == 0) ? dout0 : dout1;
         if (v) begin
            if (q_exp[d].size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output dut%0d @cyc %0d: got valid data %h, required no output", d, cyc, o);
            end else begin
               e = q_exp[d].pop_front();
               if (pos[d] == 0) check("first_out_cycle", d, 64'(cyc), 64'(q_start[d].pop_front()));
               check("data_out", d, o, e.data);
               check("data_out_last", d, {63'b0, l}, {63'b0, e.last});
               pos[d] = (pos[d] + 1) % (1 << nbits(d));
            end
         end else begin
            check("idle_data_zero", d, o, 64'h0);
            if (pos[d] != 0) check("valid_contiguous", d, {63'b0, v}, 64'h1);
         end
         if (!rst_n[d]) begin
            q_exp[d].delete();
            q_start[d].delete();
            pos[d] = 0;
         end
      end
   end

   initial begin
      int c0;
      cyc   = 0;
      tests = 0;
      fails = 0;
      rst_n = 2'b00;
      din_v = 2'b00;
      din[0] = '0;
      din[1] = '0;
      fcnt  = '{0, 0};
      pos   = '{0, 0};
      repeat (3) @(posedge clk);
      #1;
      rst_n = 2'b11;

      // consecutive frame 0..7
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 64'(i));
      idle(0, 12);
      // same frame with valid toggling
      for (int i = 0; i < 8; i++) begin
         drive(0, 1'b1, 64'(i));
         if (i != 7) drive(0, 1'b0, 64'h0);
      end
      idle(0, 12);
      // three back-to-back full-rate frames
      for (int i = 0; i < 24; i++) drive(0, 1'b1, 64'(i));
      idle(0, 12);
      // partial frame discarded by reset, valid during reset ignored
      for (int i = 0; i < 5; i++) drive(0, 1'b1, 64'(200 + i));
      do_reset(0);
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 64'(100 + i));
      idle(0, 12);
      // reset on the 3rd output cycle truncates the frame
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 64'(300 + i));
      c0 = cyc;
      while (cyc < c0 + 5) drive(0, 1'b0, 64'h0);
      rst_n[0] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      idle(0, 12);
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 64'(400 + i));
      idle(0, 12);

      // randomized 64-point frames with random gaps
      for (int f = 0; f < 10; f++) begin
         int k = 0;
         while (k < 64) begin
            if ($urandom_range(0, 3) != 0) begin
               drive(1, 1'b1, {$urandom, $urandom});
               k++;
            end else begin
               drive(1, 1'b0, 64'h0);
            end
         end
         if ($urandom_range(0, 1) == 1) idle(1, $urandom_range(0, 20));
      end
      idle(1, 80);
      idle(0, 4);

      for (int d = 0; d < 2; d++) begin
         check("pending_expected", d, 64'(q_exp[d].size()), 64'h0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer at the tail of the radix-2 DIF pipeline. The last butterfly stage emits each frame in bit-reversed index order; this block collects one frame, then streams it out in natural index order. Two RAM banks ping-pong: one is written while the other is read, so continuous input streams through with no stalls.

## Interface
- float_len, 32, width of one real or imaginary float; sample width is 2*float_len.
- bram_addr_len, 6, log2 of frame length N (N = 2^bram_addr_len points).
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset, synchronous, active-low.
- data_in  in  2*float_len  sample from the last radix stage, {real, imag}, bit-reversed order.
- data_in_valid  in  1  data_in is a sample this cycle; any duty cycle, no backpressure.
- data_out  out  2*float_len  sample in natural order; 0 when data_out_valid=0.
- data_out_valid  out  1  data_out valid; high for exactly N consecutive cycles per frame.
- data_out_last  out  1  high with the final sample (index N-1) of each output frame.

## Operation
- Storage: two banks, each N x 2*float_len, inferred simple dual-port RAM with registered read.
- Write side:
  - wr_cnt (bram_addr_len bits) counts accepted samples.
  - wr_bank selects the target bank.
  - On data_in_valid, write data_in to bank[wr_bank] at address bitrev(wr_cnt), where bit i maps to bit bram_addr_len-1-i; then increment wr_cnt.
  - When wr_cnt = N-1 is written, wr_cnt wraps to 0, wr_bank toggles, and a one-cycle done pulse is registered for the finished bank.
- Read side FSM, states IDLE and READ:
  - IDLE: on done pulse, go to READ with rd_bank = finished bank, rd_cnt = 0.
  - READ: issue a read of bank[rd_bank] at rd_cnt each cycle, then increment.
  - After issuing rd_cnt = N-1: if a done pulse arrives the same cycle, stay in READ on the other bank with rd_cnt = 0; otherwise go to IDLE.
- Because input is at most one sample per cycle, the next frame completes no earlier than N cycles after the previous one, so the reader always finishes a bank before the writer re-enters it. No overrun detection is required.
- Arithmetic: the block never modifies data; address math is modulo N.

## Timing
- The done pulse is asserted the cycle after the last write of a frame, call it cycle t. Read address j is issued at t+j for j = 0..N-1.
- data_out for index j appears at t+1+j. That is 2 cycles from the clock edge that accepts the last input sample to the first output.
- data_out_valid and data_out_last are registered and aligned with data_out.
- Back-to-back frames at full rate produce a continuous data_out_valid, with no bubble between frames.
- Reset (rst=0 at a clock edge) clears wr_cnt, rd_cnt, wr_bank, rd_bank, the done pulse, the FSM (to IDLE), data_out, data_out_valid and data_out_last.
  - RAM contents are not cleared.
  - A partial input frame is discarded, and an in-progress output frame is truncated immediately.
  - The first valid sample after reset release is index 0 of a new frame.
- data_in_valid=1 during reset is ignored.

## Test plan
- N=8, inputs 0..7 on consecutive cycles -> data_out 0,4,2,6,1,5,3,7 on 8 consecutive cycles, first output 2 cycles after the last input edge, data_out_last with 7.
- N=8, same values with valid toggling 1,0,1,0 -> identical output sequence, contiguous 8-cycle valid burst, same 2-cycle latency from the last input.
- N=8, three back-to-back full-rate frames with values 0..23 -> 24 contiguous valid cycles: 0,4,2,6,1,5,3,7, 8,12,10,14,9,13,11,15, 16,20,...,23; data_out_last at 7, 15, 23.
- N=8, reset asserted after 5 inputs of frame A, then a fresh frame 100..107 -> no output for A; output 100,104,102,106,101,105,103,107.
- N=8, reset asserted on the 3rd output cycle -> data_out_valid=0 and data_out=0 on the next cycle, with no further outputs until a new full frame arrives.
- N=64 default, random 64-bit samples over 10 frames with random valid gaps -> each output frame equals input[bitrev6(j)] for j = 0..63; data_out=0 whenever data_out_valid=0.
